// File: rtl/p18_sync_debounce.sv
// Multi-channel input conditioner: STAGES-deep synchroniser, optional debounce
// filter (enabled by `P18_SYNC_DEBOUNCE_EN), and registered rise/fall pulses.
module p18_sync_debounce #(
    parameter int               WIDTH           = 4,
    parameter int               STAGES          = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE   = {WIDTH{1'b0}},
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (STAGES < 2 || DEBOUNCE_CYCLES < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("p18_sync_debounce: STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             s;
    logic [WIDTH-1:0]             out_q;
    logic [WIDTH-1:0]             out_d;
    logic [WIDTH-1:0]             rise_q;
    logic [WIDTH-1:0]             fall_q;

    // Index 0 samples the pin; the top index is the synchronised level.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= {STAGES{DEFAULT_VALUE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in};
        end
    end

    assign s = sync_q[STAGES-1];

`ifdef P18_SYNC_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

    // cnt counts consecutive cycles of disagreement; any agreement restarts it.
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                out_d[i] = s[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign out_d = s;
`endif

    // Pulses are computed from the same next value that loads out_q, so they
    // line up with the cycle in which out first shows the new level.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            out_q  <= DEFAULT_VALUE;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            out_q  <= out_d;
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_p18_sync_debounce.sv
// Bench for p18_sync_debounce: directed vector table, hand-written corner
// sequences and a randomized run against a delay-line/window reference model.
module tb_p18_sync_debounce;

    localparam int         W      = 4;
    localparam int         STAGES = 3;
    localparam int         DEB    = 4;
    localparam logic [3:0] DEF    = 4'b1010;
`ifdef P18_SYNC_DEBOUNCE_EN
    localparam int EFF_D       = DEB;
    localparam int EXP_BOUNCE  = 1;
`else
    localparam int EFF_D       = 1;
    localparam int EXP_BOUNCE  = 6;
`endif
    localparam int LAT = STAGES - 1 + EFF_D;

    typedef struct {
        logic [3:0] in_v;
        logic [3:0] out_v;
        logic [3:0] rise_v;
        logic [3:0] fall_v;
    } vec_t;

    logic       clk  = 1'b0;
    logic       nRst = 1'b0;
    logic [3:0] din  = 4'b0101;
    logic [3:0] dout;
    logic [3:0] drise;
    logic [3:0] dfall;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    p18_sync_debounce #(
        .WIDTH(W),
        .STAGES(STAGES),
        .DEFAULT_VALUE(DEF),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .in(din),
        .out(dout),
        .rise(drise),
        .fall(dfall)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // in_hist is a pure delay line of pin samples; s_hist holds the synchronised
    // level seen at each edge since reset (at most EFF_D of them). A channel takes
    // the new level when all of the last EFF_D levels disagree with its output.
    logic [3:0] in_hist[$];
    logic [3:0] s_hist[$];
    logic [3:0] m_out;
    logic [3:0] m_rise;
    logic [3:0] m_fall;
    logic [3:0] s_now;
    logic [3:0] nxt;
    bit         agree;

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            in_hist.delete();
            s_hist.delete();
            for (int k = 0; k < STAGES; k++) in_hist.push_back(DEF);
            m_out  = DEF;
            m_rise = '0;
            m_fall = '0;
        end else begin
            s_now = in_hist.pop_front();
            in_hist.push_back(din);
            s_hist.push_back(s_now);
            if (s_hist.size() > EFF_D) void'(s_hist.pop_front());
            nxt = m_out;
            for (int i = 0; i < W; i++) begin
                agree = 1'b0;
                foreach (s_hist[k]) if (s_hist[k][i] == m_out[i]) agree = 1'b1;
                if (s_hist.size() == EFF_D && !agree) nxt[i] = s_now[i];
            end
            m_rise = nxt & ~m_out;
            m_fall = ~nxt & m_out;
            m_out  = nxt;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out", dout, m_out);
            check("model_rise", drise, m_rise);
            check("model_fall", dfall, m_fall);
        end
    end

    // ---------------- driver ----------------
    // Drive a value just after a falling edge; return after the next falling
    // edge, i.e. with the result of one rising edge visible.
    task automatic step(input logic [3:0] v);
        din = v;
        @(negedge clk);
    endtask

    task automatic settle(input logic [3:0] v);
        repeat (LAT + 2) step(v);
    endtask

    vec_t tbl[9];
    int   nr;
    int   nf;
    int   r_at;
    int   f_at;
    logic [3:0] rv;

    initial begin
`ifdef P18_SYNC_DEBOUNCE_EN
        tbl = '{
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0001, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0000, 4'b0000}
        };
`else
        tbl = '{
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1010, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0001, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0000, 4'b0000},
            '{4'b1011, 4'b1011, 4'b0000, 4'b0000}
        };
`endif

        // Reset with the pins already away from the default.
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_out", dout, DEF);
        check("rst_rise", drise, 4'b0000);
        check("rst_fall", dfall, 4'b0000);
        nRst = 1'b1;
        for (int j = 0; j <= LAT + 1; j++) begin
            step(4'b0101);
            check("rel_out", dout, (j < LAT) ? DEF : 4'b0101);
            check("rel_rise", drise, (j == LAT) ? 4'b0101 : 4'b0000);
            check("rel_fall", dfall, (j == LAT) ? 4'b1010 : 4'b0000);
        end
        settle(DEF);

        // Clean step on channel 0.
        for (int r = 0; r < 9; r++) begin
            step(tbl[r].in_v);
            check("tbl_out", dout, tbl[r].out_v);
            check("tbl_rise", drise, tbl[r].rise_v);
            check("tbl_fall", dfall, tbl[r].fall_v);
        end
        settle(DEF);

`ifdef P18_SYNC_DEBOUNCE_EN
        // Pulse one cycle too short to pass the filter.
        nr = 0;
        nf = 0;
        repeat (EFF_D - 1) begin
            step(4'b1110);
            nr += int'(drise[2]);
            nf += int'(dfall[2]);
        end
        repeat (LAT + 3) begin
            step(DEF);
            nr += int'(drise[2]);
            nf += int'(dfall[2]);
        end
        check("short_rise_cnt", 4'(nr), 4'd0);
        check("short_fall_cnt", 4'(nf), 4'd0);
`endif

        // Pulse just long enough: one rise, then one fall.
        nr = 0;
        nf = 0;
        r_at = -1;
        f_at = -1;
        for (int j = 0; j < EFF_D + LAT + 3; j++) begin
            step((j < EFF_D) ? 4'b1110 : DEF);
            if (drise[2]) begin
                nr++;
                r_at = j;
            end
            if (dfall[2]) begin
                nf++;
                f_at = j;
            end
        end
        check("pulse_rise_cnt", 4'(nr), 4'd1);
        check("pulse_fall_cnt", 4'(nf), 4'd1);
        check("pulse_rise_at", 4'(r_at), 4'(LAT));
        check("pulse_fall_at", 4'(f_at), 4'(LAT + EFF_D));

        // Bounce on channel 1: ten 3-cycle runs, then settle high.
        settle(4'b1000);
        nr = 0;
        r_at = -1;
        for (int run = 0; run < 10; run++) begin
            repeat (3) begin
                step((run % 2 == 0) ? 4'b1010 : 4'b1000);
                nr += int'(drise[1]);
            end
        end
        for (int j = 0; j <= LAT + 2; j++) begin
            step(4'b1010);
            if (drise[1]) begin
                nr++;
                r_at = j;
            end
        end
        check("bounce_rise_cnt", 4'(nr), 4'(EXP_BOUNCE));
        check("bounce_rise_at", 4'(r_at), 4'(LAT));

        // Reset in the middle of a count on channel 3.
        settle(4'b0101);
        repeat (LAT - 1) step(4'b1101);
        check("midrst_pre_out", dout, 4'b0101);
        #2 nRst = 1'b0;
        #1;
        check("midrst_out", dout, DEF);
        check("midrst_rise", drise, 4'b0000);
        check("midrst_fall", dfall, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        for (int j = 0; j <= LAT + 1; j++) begin
            step(4'b1101);
            check("midrst_rel_out", dout, (j < LAT) ? DEF : 4'b1101);
            check("midrst_rel_rise", drise, (j == LAT) ? 4'b0101 : 4'b0000);
            check("midrst_rel_fall", dfall, (j == LAT) ? 4'b0010 : 4'b0000);
        end

        // Randomized pins, with one asynchronous reset in the middle.
        for (int c = 0; c < 600; c++) begin
            rv = din;
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0) rv[i] = ~rv[i];
            end
            step(rv);
            if (c == 300) begin
                #3 nRst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                nRst = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
